dma_engine_mc: RTL and testbench



---
 rtl/dma_pkg.sv | 35 +++
 rtl/dma_engine_mc_if.sv | 28 ++
 rtl/dma_rr_arbiter.sv | 53 +++++
 rtl/dma_engine_mc.sv | 256 +++++++++++++++++++++++++
 tb/tb_dma_engine_mc.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared types for the multi-channel DMA engine.
// Contents:
//   iommu_op_t       - IOMMU operation codes (OP_XLATE, OP_READ, OP_WRITE)
//   dma_state_t      - engine FSM states
//   onehot8_to_idx() - binary index of a one-hot vector of up to 8 bits
package dma_pkg;

  typedef enum logic [1:0] {
    OP_XLATE = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } iommu_op_t;

  typedef enum logic [2:0] {
    ST_ARB       = 3'd0,
    ST_SRC_XLATE = 3'd1,
    ST_SRC_READ  = 3'd2,
    ST_DST_XLATE = 3'd3,
    ST_DST_WRITE = 3'd4,
    ST_ADVANCE   = 3'd5
  } dma_state_t;

  // Channel count is capped at 8, so an 8-bit one-hot input covers every grant.
  function automatic logic [2:0] onehot8_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/dma_engine_mc_if.sv
// IOMMU request/response bus between the DMA engine and the IOMMU.
// Signals:
//   req   - operation request, held until ack
//   op    - OP_XLATE / OP_READ / OP_WRITE
//   addr  - virtual (XLATE) or physical (READ/WRITE) address
//   wdata - write data
//   ack   - operation complete (may come in the first cycle req is high)
//   rdata - translated address or read data, valid with ack
//   fault - translation fault, valid with ack on XLATE
// Modports: master (engine side), slave (IOMMU side).
interface dma_engine_mc_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import dma_pkg::*;

  logic              req;
  iommu_op_t         op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              fault;

  modport master (output req, op, addr, wdata, input ack, rdata, fault);
  modport slave  (input req, op, addr, wdata, output ack, rdata, fault);

endinterface

// File: rtl/dma_rr_arbiter.sv
// Round-robin arbiter for the DMA channels.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   req        - per-channel request vector
//   advance    - consume the current grant; priority moves past the winner
//   gnt        - one-hot grant (combinational from req and the pointer)
module dma_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_s;
  logic [PW-1:0] idx_v;
  logic          found_s;

  // Search from the pointer upward (wrapping) for the first requester.
  always_comb begin
    gnt     = '0;
    ptr_s   = ptr_r;
    found_s = 1'b0;
    idx_v   = '0;
    for (int i = 0; i < N; i++) begin
      idx_v = PW'((int'(ptr_r) + i) % N);
      if (!found_s && req[idx_v]) begin
        gnt[idx_v] = 1'b1;
        found_s    = 1'b1;
        ptr_s      = PW'((int'(idx_v) + 1) % N);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Rotating priority pointer; moves only when a grant is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (advance && found_s) begin
      ptr_r <= ptr_s;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/dma_engine_mc.sv
// Multi-channel DMA engine. NUM_CH copy channels share one IOMMU port and
// interleave at beat granularity; each beat is XLATE(src), READ, XLATE(dst),
// WRITE, then ADVANCE updates the owning channel.
// Ports:
//   clk, reset              - clock, synchronous active-high reset
//   ch_src_addr/ch_dst_addr - per-channel virtual addresses, sampled on start
//   ch_size                 - per-channel byte count, sampled on start
//   ch_start, ch_abort      - per-channel start pulse / abort request
//   ch_busy, ch_done, ch_error - per-channel status (done/error sticky)
//   iommu                   - IOMMU bus, master side
module dma_engine_mc
  import dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_src_addr,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_dst_addr,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  ch_size,
  input  logic [NUM_CH-1:0]              ch_start,
  input  logic [NUM_CH-1:0]              ch_abort,
  output logic [NUM_CH-1:0]              ch_busy,
  output logic [NUM_CH-1:0]              ch_done,
  output logic [NUM_CH-1:0]              ch_error,
  dma_engine_mc_if.master                iommu
);

  localparam int                BEAT_BYTES = DATA_W / 8;
  localparam int                CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [ADDR_W-1:0] BEAT_INC   = ADDR_W'(BEAT_BYTES);

  // Remaining-byte decrement that stops at zero (final partial beat).
  function automatic logic [ADDR_W-1:0] sat_dec(input logic [ADDR_W-1:0] r);
    if (r > BEAT_INC) begin
      return r - BEAT_INC;
    end else begin
      return '0;
    end
  endfunction

  // Per-channel state
  logic [ADDR_W-1:0] src_r [NUM_CH];
  logic [ADDR_W-1:0] dst_r [NUM_CH];
  logic [ADDR_W-1:0] rem_r [NUM_CH];
  logic [NUM_CH-1:0] busy_r, done_r, error_r, abort_pend_r;

  // Engine state
  dma_state_t        state_r, state_s;
  logic [CH_W-1:0]   cur_r, cur_s;
  logic [ADDR_W-1:0] paddr_r, paddr_s;
  logic              fault_r, fault_s;
  logic              req_r, req_s;
  iommu_op_t         op_r, op_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;

  logic [NUM_CH-1:0] arb_req_s, gnt_s;
  logic [CH_W-1:0]   gnt_idx_s;
  logic              arb_adv_s;
  logic              ack_s;
  logic [ADDR_W-1:0] phys_s;

  // Aborting channels (pending or requested this cycle) never compete.
  assign arb_req_s = busy_r & ~abort_pend_r & ~ch_abort;
  assign arb_adv_s = (state_r == ST_ARB) && (|arb_req_s);
  assign gnt_idx_s = CH_W'(onehot8_to_idx(8'(gnt_s)));
  assign ack_s     = req_r & iommu.ack;
  assign phys_s    = ADDR_W'(iommu.rdata);

  dma_rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (arb_req_s),
    .advance (arb_adv_s),
    .gnt     (gnt_s)
  );

  // Next-state and next-output logic. Bus outputs are registered: each
  // transition loads the op/address of the state being entered, so req
  // stays high back-to-back across the four operations of a beat.
  always_comb begin
    state_s = state_r;
    cur_s   = cur_r;
    paddr_s = paddr_r;
    fault_s = fault_r;
    req_s   = req_r;
    op_s    = op_r;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    case (state_r)
      ST_ARB: begin
        if (|arb_req_s) begin
          state_s = ST_SRC_XLATE;
          cur_s   = gnt_idx_s;
          fault_s = 1'b0;
          req_s   = 1'b1;
          op_s    = OP_XLATE;
          addr_s  = src_r[gnt_idx_s];
        end else begin
          req_s = 1'b0;
        end
      end
      ST_SRC_XLATE: begin
        if (ack_s) begin
          if (iommu.fault) begin
            state_s = ST_ADVANCE;
            fault_s = 1'b1;
            req_s   = 1'b0;
          end else begin
            state_s = ST_SRC_READ;
            paddr_s = phys_s;
            op_s    = OP_READ;
            addr_s  = phys_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_SRC_READ: begin
        if (ack_s) begin
          state_s = ST_DST_XLATE;
          wdata_s = iommu.rdata;
          op_s    = OP_XLATE;
          addr_s  = dst_r[cur_r];
        end else begin
          state_s = state_r;
        end
      end
      ST_DST_XLATE: begin
        if (ack_s) begin
          if (iommu.fault) begin
            state_s = ST_ADVANCE;
            fault_s = 1'b1;
            req_s   = 1'b0;
          end else begin
            state_s = ST_DST_WRITE;
            paddr_s = phys_s;
            op_s    = OP_WRITE;
            addr_s  = phys_s;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_DST_WRITE: begin
        if (ack_s) begin
          state_s = ST_ADVANCE;
          req_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_ADVANCE: begin
        state_s = ST_ARB;
      end
      default: begin
        state_s = ST_ARB;
        req_s   = 1'b0;
      end
    endcase
  end

  // Engine state and registered IOMMU outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_ARB;
      cur_r   <= '0;
      paddr_r <= '0;
      fault_r <= 1'b0;
      req_r   <= 1'b0;
      op_r    <= OP_XLATE;
      addr_r  <= '0;
      wdata_r <= '0;
    end else begin
      state_r <= state_s;
      cur_r   <= cur_s;
      paddr_r <= paddr_s;
      fault_r <= fault_s;
      req_r   <= req_s;
      op_r    <= op_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  // Per-channel registers: start, beat advance/retire, and abort handling.
  // An abort on the channel that owns the engine is parked until ADVANCE so
  // the beat in flight finishes cleanly.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r       <= '0;
      done_r       <= '0;
      error_r      <= '0;
      abort_pend_r <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        src_r[c] <= '0;
        dst_r[c] <= '0;
        rem_r[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_start[c] && !busy_r[c]) begin
          src_r[c]        <= ch_src_addr[c];
          dst_r[c]        <= ch_dst_addr[c];
          rem_r[c]        <= ch_size[c];
          busy_r[c]       <= (ch_size[c] != '0);
          done_r[c]       <= (ch_size[c] == '0);
          error_r[c]      <= 1'b0;
          abort_pend_r[c] <= 1'b0;
        end else if ((state_r == ST_ADVANCE) && (cur_r == CH_W'(c))) begin
          if (fault_r) begin
            busy_r[c]       <= 1'b0;
            done_r[c]       <= 1'b1;
            error_r[c]      <= 1'b1;
            abort_pend_r[c] <= 1'b0;
          end else begin
            src_r[c] <= src_r[c] + BEAT_INC;
            dst_r[c] <= dst_r[c] + BEAT_INC;
            rem_r[c] <= sat_dec(rem_r[c]);
            if ((sat_dec(rem_r[c]) == '0) || abort_pend_r[c] || ch_abort[c]) begin
              busy_r[c]       <= 1'b0;
              done_r[c]       <= 1'b1;
              error_r[c]      <= 1'b0;
              abort_pend_r[c] <= 1'b0;
            end else begin
              busy_r[c] <= busy_r[c];
            end
          end
        end else if (ch_abort[c]) begin
          if ((state_r != ST_ARB) && (cur_r == CH_W'(c))) begin
            abort_pend_r[c] <= 1'b1;
          end else begin
            busy_r[c]       <= 1'b0;
            done_r[c]       <= 1'b1;
            error_r[c]      <= 1'b0;
            abort_pend_r[c] <= 1'b0;
          end
        end else begin
          busy_r[c] <= busy_r[c];
        end
      end
    end
  end

  assign ch_busy     = busy_r;
  assign ch_done     = done_r;
  assign ch_error    = error_r;
  assign iommu.req   = req_r;
  assign iommu.op    = op_r;
  assign iommu.addr  = addr_r;
  assign iommu.wdata = wdata_r;

endmodule

// File: tb/tb_dma_engine_mc.sv
// Directed testbench for dma_engine_mc with an identity-translating IOMMU
// model (optional random wait states and a single faulting address).
module tb_dma_engine_mc;
  import dma_pkg::*;

  localparam int NUM_CH = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_src_addr, ch_dst_addr, ch_size;
  logic [NUM_CH-1:0] ch_start, ch_abort, ch_busy, ch_done, ch_error;

  dma_engine_mc_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) io ();

  dma_engine_mc #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_src_addr (ch_src_addr),
    .ch_dst_addr (ch_dst_addr),
    .ch_size     (ch_size),
    .ch_start    (ch_start),
    .ch_abort    (ch_abort),
    .ch_busy     (ch_busy),
    .ch_done     (ch_done),
    .ch_error    (ch_error),
    .iommu       (io)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit wait_en  = 1'b0;
  bit fault_en = 1'b0;
  logic [31:0] fault_addr = 32'h0;
  logic [31:0] xl_q[$], rd_q[$], wa_q[$], wd_q[$];
  int req_cnt = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0042;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    xl_q.delete(); rd_q.delete(); wa_q.delete(); wd_q.delete();
    req_cnt = 0;
  endtask

  task automatic start_ch(input int c, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] n);
    @(negedge clk);
    ch_src_addr[c] = s; ch_dst_addr[c] = d; ch_size[c] = n; ch_start[c] = 1'b1;
    @(negedge clk);
    ch_start[c] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int c, input int budget, output int cyc);
    cyc = 0;
    while (ch_done[c] !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    check(tag, 64'(ch_done[c]), 64'd1);
  endtask

  task automatic wait_op(input string tag, input iommu_op_t op);
    int n;
    n = 0;
    while (!(io.req === 1'b1 && io.op === op) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(io.req === 1'b1 && io.op === op), 64'd1);
  endtask

  // IOMMU model: responds at the falling edge so ack is sampled at the next rise.
  bit          pend = 1'b0;
  int          wl = 0;
  iommu_op_t   cap_op = OP_XLATE;
  logic [31:0] cap_addr = 32'h0, cap_wdata = 32'h0;
  initial begin
    io.ack = 1'b0; io.rdata = 32'h0; io.fault = 1'b0;
    forever begin
      @(negedge clk);
      if (io.req === 1'b1) begin
        req_cnt++;
        if (pend) begin
          check("stable_op", 64'(io.op), 64'(cap_op));
          check("stable_addr", 64'(io.addr), 64'(cap_addr));
          check("stable_wdata", 64'(io.wdata), 64'(cap_wdata));
        end else begin
          pend = 1'b1;
          cap_op = io.op; cap_addr = io.addr; cap_wdata = io.wdata;
          wl = wait_en ? int'($urandom_range(5, 0)) : 0;
        end
        if (wl == 0) begin
          io.ack = 1'b1; io.fault = 1'b0; pend = 1'b0;
          case (io.op)
            OP_XLATE: begin
              xl_q.push_back(io.addr);
              if (fault_en && io.addr == fault_addr) begin
                io.fault = 1'b1; io.rdata = 32'h0;
              end else begin
                io.rdata = io.addr;
              end
            end
            OP_READ: begin
              rd_q.push_back(io.addr);
              io.rdata = memf(io.addr);
            end
            OP_WRITE: begin
              wa_q.push_back(io.addr);
              wd_q.push_back(io.wdata);
            end
            default: io.rdata = 32'h0;
          endcase
        end else begin
          io.ack = 1'b0; wl--;
        end
      end else begin
        io.ack = 1'b0; io.fault = 1'b0; pend = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, bad, n8, n9;
    logic [31:0] ord[$];
    reset = 1'b1;
    ch_src_addr = '0; ch_dst_addr = '0; ch_size = '0; ch_start = '0; ch_abort = '0;
    repeat (3) @(negedge clk);
    check("rst_req", 64'(io.req), 64'd0);
    check("rst_op", 64'(io.op), 64'(OP_XLATE));
    check("rst_addr", 64'(io.addr), 64'd0);
    check("rst_wdata", 64'(io.wdata), 64'd0);
    check("rst_flags", 64'({ch_busy, ch_done, ch_error}), 64'd0);
    reset = 1'b0;

    // 64 bytes on channel 0, zero-wait: 16 beats of 6 cycles
    clear_logs();
    start_ch(0, 32'h1000, 32'h2000, 32'd64);
    wait_done("t1_done", 0, 400, cyc);
    check("t1_cycles", 64'(cyc), 64'd96);
    check("t1_writes", 64'(wa_q.size()), 64'd16);
    check("t1_reads", 64'(rd_q.size()), 64'd16);
    bad = 0;
    for (int i = 0; i < wa_q.size(); i++) begin
      if (wa_q[i] !== 32'h2000 + 32'(4 * i) || wd_q[i] !== memf(32'h1000 + 32'(4 * i))) bad++;
    end
    check("t1_data", 64'(bad), 64'd0);
    check("t1_err_busy", 64'({ch_error[0], ch_busy[0]}), 64'd0);

    // size 5 -> 2 beats
    clear_logs();
    start_ch(0, 32'h3000, 32'h4000, 32'd5);
    wait_done("t2_done", 0, 100, cyc);
    check("t2_cycles", 64'(cyc), 64'd12);
    check("t2_writes", 64'(wa_q.size()), 64'd2);
    check("t2_wa1", 64'(wa_q[1]), 64'h4004);
    check("t2_wd1", 64'(wd_q[1]), 64'(memf(32'h3004)));

    // size 0 -> done next cycle, no bus traffic
    clear_logs();
    start_ch(3, 32'h3000, 32'h4000, 32'd0);
    check("t2z_done", 64'({ch_done[3], ch_busy[3]}), 64'b10);
    repeat (4) @(negedge clk);
    check("t2z_noreq", 64'(req_cnt), 64'd0);

    // two channels interleave, pointer freshly reset to 0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    clear_logs();
    @(negedge clk);
    ch_src_addr[0] = 32'h5000; ch_dst_addr[0] = 32'hD000; ch_size[0] = 32'd8;
    ch_src_addr[2] = 32'h6000; ch_dst_addr[2] = 32'hE000; ch_size[2] = 32'd8;
    ch_start = 4'b0101;
    @(negedge clk);
    ch_start = 4'b0000;
    wait_done("t3_done0", 0, 200, cyc);
    wait_done("t3_done2", 2, 200, cyc);
    ord.delete();
    foreach (xl_q[i]) if (xl_q[i][15:12] == 4'h5 || xl_q[i][15:12] == 4'h6) ord.push_back(xl_q[i]);
    check("t3_nsrc", 64'(ord.size()), 64'd4);
    check("t3_g0", 64'(ord[0]), 64'h5000);
    check("t3_g1", 64'(ord[1]), 64'h6000);
    check("t3_g2", 64'(ord[2]), 64'h5004);
    check("t3_g3", 64'(ord[3]), 64'h6004);
    check("t3_writes", 64'(wa_q.size()), 64'd4);

    // fault on third destination translation of channel 1
    clear_logs();
    fault_en = 1'b1; fault_addr = 32'h9008;
    @(negedge clk);
    ch_src_addr[0] = 32'h1000; ch_dst_addr[0] = 32'h8000; ch_size[0] = 32'd16;
    ch_src_addr[1] = 32'h7000; ch_dst_addr[1] = 32'h9000; ch_size[1] = 32'd32;
    ch_start = 4'b0011;
    @(negedge clk);
    ch_start = 4'b0000;
    wait_done("t4_done1", 1, 400, cyc);
    wait_done("t4_done0", 0, 400, cyc);
    fault_en = 1'b0;
    n8 = 0; n9 = 0; bad = 0;
    foreach (wa_q[i]) begin
      if (wa_q[i][15:12] == 4'h8) begin
        n8++;
        if (wd_q[i] !== memf(wa_q[i] - 32'h7000)) bad++;
      end else if (wa_q[i][15:12] == 4'h9) begin
        n9++;
        if (wd_q[i] !== memf(wa_q[i] - 32'h2000)) bad++;
      end else begin
        bad++;
      end
    end
    check("t4_ch1_writes", 64'(n9), 64'd2);
    check("t4_ch0_writes", 64'(n8), 64'd4);
    check("t4_data", 64'(bad), 64'd0);
    check("t4_ch1_err", 64'({ch_error[1], ch_busy[1]}), 64'b10);
    check("t4_ch0_err", 64'(ch_error[0]), 64'd0);

    // abort on an idle channel
    check("t4i_pre", 64'(ch_done[3]), 64'd0);
    @(negedge clk);
    ch_abort[3] = 1'b1;
    @(negedge clk);
    ch_abort[3] = 1'b0;
    check("t4i_abort", 64'({ch_done[3], ch_error[3], ch_busy[3]}), 64'b100);

    // abort granted channel during its first SRC_READ, random wait states
    wait_en = 1'b1;
    clear_logs();
    start_ch(0, 32'h1000, 32'hA000, 32'd64);
    wait_op("t5_read_seen", OP_READ);
    ch_abort[0] = 1'b1;
    @(negedge clk);
    ch_abort[0] = 1'b0;
    wait_done("t5_done", 0, 500, cyc);
    repeat (10) @(negedge clk);
    check("t5_writes", 64'(wa_q.size()), 64'd1);
    check("t5_reads", 64'(rd_q.size()), 64'd1);
    check("t5_wa0", 64'(wa_q[0]), 64'hA000);
    check("t5_wd0", 64'(wd_q[0]), 64'(memf(32'h1000)));
    check("t5_flags", 64'({ch_done[0], ch_error[0], ch_busy[0]}), 64'b100);

    // reset during DST_WRITE, then a clean restart
    start_ch(1, 32'h1000, 32'hC000, 32'd16);
    wait_op("t6_write_seen", OP_WRITE);
    reset = 1'b1;
    @(negedge clk);
    check("t6_req", 64'(io.req), 64'd0);
    check("t6_flags", 64'({ch_busy, ch_done, ch_error}), 64'd0);
    reset = 1'b0;
    clear_logs();
    start_ch(1, 32'h1100, 32'hB000, 32'd8);
    wait_done("t6_done", 1, 500, cyc);
    check("t6_err", 64'(ch_error[1]), 64'd0);
    check("t6_writes", 64'(wa_q.size()), 64'd2);
    check("t6_wd0", 64'(wd_q[0]), 64'(memf(32'h1100)));
    check("t6_wa1", 64'(wa_q[1]), 64'hB004);
    check("t6_wd1", 64'(wd_q[1]), 64'(memf(32'h1104)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
